// File: rtl/cacheline_adaptor_if.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_adaptor_if
// Brief    : Arbiter line port plus physical memory burst port.
// Revision : 1.0
// ============================================================================
interface cacheline_adaptor_if #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
);
    logic                   pmem_read_cla;
    logic                   pmem_write_cla;
    logic [31:0]            pmem_address_cla;
    logic [LINE_WIDTH-1:0]  pmem_wdata_256_cla;
    logic                   pmem_resp_cla;
    logic [LINE_WIDTH-1:0]  pmem_rdata_256_cla;
    logic [31:0]            address_o;
    logic                   read_o;
    logic                   write_o;
    logic [BURST_WIDTH-1:0] burst_o;
    logic [BURST_WIDTH-1:0] burst_i;
    logic                   resp_i;

    modport slave (
        input  pmem_read_cla, pmem_write_cla, pmem_address_cla, pmem_wdata_256_cla,
        input  burst_i, resp_i,
        output pmem_resp_cla, pmem_rdata_256_cla, address_o, read_o, write_o, burst_o
    );

    modport master (
        output pmem_read_cla, pmem_write_cla, pmem_address_cla, pmem_wdata_256_cla,
        output burst_i, resp_i,
        input  pmem_resp_cla, pmem_rdata_256_cla, address_o, read_o, write_o, burst_o
    );
endinterface
`default_nettype wire

// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_adaptor
// Brief    : Converts one 256-bit line read/write into a 4-beat memory burst.
// Revision : 1.0
// ============================================================================
module cacheline_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int OFFSET_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    cacheline_adaptor_if.slave   bus
);
    localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [31:0]           addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                // Read takes priority when both requests are (illegally) high
                if (bus.pmem_read_cla) begin
                    addr_d  = {bus.pmem_address_cla[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    cnt_d   = '0;
                    state_d = READ;
                end else if (bus.pmem_write_cla) begin
                    addr_d  = {bus.pmem_address_cla[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    wdata_d = bus.pmem_wdata_256_cla;
                    cnt_d   = '0;
                    state_d = WRITE;
                end
            end
            READ: begin
                if (bus.resp_i) begin
                    rdata_d[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH] = bus.burst_i;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (bus.resp_i) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode from registered state only, so rst clears them at once
    assign bus.pmem_resp_cla      = (state_q == DONE);
    assign bus.read_o             = (state_q == READ);
    assign bus.write_o            = (state_q == WRITE);
    assign bus.address_o          = ((state_q == READ) || (state_q == WRITE)) ? addr_q : '0;
    assign bus.burst_o            = (state_q == WRITE) ?
                                    wdata_q[int'(cnt_q)*BURST_WIDTH +: BURST_WIDTH] : '0;
    assign bus.pmem_rdata_256_cla = rdata_q;
endmodule
`default_nettype wire
